i2c_reg_bank: RTL
=================

Name: i2c_reg_bank

Overview:
- Register bank directly downstream of the I2C slave. It consumes the slave's write strobe, index and write data, and returns read data for the slave's read strobe.
- Holds 15 RW shadow config bytes, one control byte and 4 RO status bytes. The address window is 0x40–0x53, matching the index range the slave ACKs.
- Shadow bytes reach the BLDC control logic atomically on a commit. A watchdog disables the motor if no commit arrives in time.

Parameters:
- BASE_ADDR, 8'h40, first register index.
- NUM_CFG, 15, RW shadow bytes at BASE_ADDR .. BASE_ADDR+14.
- WDT_CYCLES, 32'd50_000_000, clk cycles without a commit before motor_en is forced low; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i2c_wr  in  1  slave write level (may stay high for several cycles per transaction).
- i2c_rd  in  1  slave read strobe.
- i2c_index  in  8  register index from the slave.
- i2c_wdata  in  8  write data from the slave.
- i2c_rdata  out  8  read data to the slave.
- status_in  in  32  live motor status (speed/fault); byte0 maps to 0x50.
- cfg_active  out  8*NUM_CFG  committed config; byte k at bits [8k+7:8k].
- motor_en  out  1  committed motor enable.
- commit_pulse  out  1  one-cycle pulse when cfg_active updates.
- wdt_trip  out  1  sticky watchdog-trip flag.
- wr_err  out  1  sticky flag: write to RO or out-of-window index.

Behaviour:
- Reset (rst=0, async): shadow=0, cfg_active=0, ctrl=0, motor_en=0, commit_pulse=0, wdt_trip=0, wr_err=0, i2c_rdata=0, snapshot=0, wdt counter=0, FSM=S_IDLE, wr_d=0, rd_d=0.
- Address map:
  - 0x40..0x4E: shadow[0..14], RW.
  - 0x4F: CTRL. bit0 = COMMIT (self-clearing, reads 0). bit1 = EN_REQ. bit7 = write 1 to clear wr_err and wdt_trip. Other bits read 0.
  - 0x50: live status_in[7:0].
  - 0x51..0x53: snapshot bytes 1..3.
  - Any other index reads 8'h00.
- Edge detect: wr_rise = i2c_wr & ~wr_d; rd_rise = i2c_rd & ~rd_d. Exactly one write is processed per rising edge.
- FSM states: S_IDLE, S_WR, S_COMMIT.
  - S_IDLE: on wr_rise, latch index/data and go to S_WR.
  - S_WR (1 cycle), decode the latched write:
    - shadow index: write the shadow byte.
    - CTRL: store EN_REQ into ctrl[1]; bit7=1 clears both sticky flags; if bit0=1 go to S_COMMIT, else S_IDLE.
    - RO or outside window: set wr_err, no state change.
  - S_COMMIT (1 cycle): cfg_active<=shadow, motor_en<=ctrl[1], commit_pulse=1, wdt counter<=0, then S_IDLE.
  - A wr_rise arriving in S_WR or S_COMMIT is held in a one-entry pending flag and serviced on return to S_IDLE. It is never dropped.
- Write→cfg_active latency: 3 clk from wr_rise at CTRL with COMMIT=1.
- Read path:
  - i2c_rdata is registered every cycle from the current i2c_index (1-cycle latency).
  - The slave sets the index many cycles before its read strobe, so data is stable when sampled.
- Snapshot: on rd_rise with i2c_index==0x50, snapshot<=status_in[31:8] in the same cycle. Later reads of 0x51..0x53 are coherent with that byte0 read.
- Watchdog (WDT_CYCLES≠0):
  - Counter increments while motor_en=1 and saturates at WDT_CYCLES.
  - On reaching WDT_CYCLES: motor_en<=0 and wdt_trip<=1.
  - Counter resets on commit_pulse and while motor_en=0.
  - A commit in the same cycle as the trip wins: motor_en follows ctrl[1] and wdt_trip is still set.
- The shadow is not altered by a commit. Repeated commits without new writes reproduce the same cfg_active.
- Async reset mid-write or mid-commit aborts the operation; all outputs return to reset values.

Decomposition:
- Shared package i2c_regmap_pkg holds:
  - register index constants (CFG_BASE, CTRL_IDX=8'h4F, STAT_IDX=8'h50, LAST_IDX=8'h53);
  - CTRL bit positions;
  - FSM state encoding.
- One natural sub-module, bank_wdt: counter, saturation, trip logic. Inputs enable/kick, output trip.

Test Plan:
- Write 0x40←0x12 then 0x4E←0xAB (i2c_wr held 5 cycles each) → shadow[0]=0x12, shadow[14]=0xAB; cfg_active unchanged (0); exactly one write per wr_rise.
- After the above, write 0x4F←0x03 → commit_pulse high exactly 1 cycle, 3 cycles after wr_rise; cfg_active[7:0]=0x12, cfg_active[119:112]=0xAB, motor_en=1; read 0x4F → 0x02.
- status_in=0xDEADBEEF: read 0x50 → 0xEF; change status_in to 0; read 0x51/0x52/0x53 → 0xBE/0xAD/0xDE.
- Write 0x51←0x55 and 0x60←0x01 → wr_err=1, snapshot and shadow unchanged; write 0x4F←0x80 → wr_err=0.
- WDT_CYCLES=100, commit with EN_REQ=1, no further traffic → motor_en falls and wdt_trip=1 at cycle 100 after commit_pulse; a commit at cycle 50 restarts the count.
- Assert rst=0 asynchronously (between clk edges) while in S_COMMIT → outputs zero immediately; after release a fresh write/commit works normally.

Source files
------------

// File: rtl/i2c_regmap_pkg.sv
// Register map constants, CTRL bit positions and write-FSM encoding for the
// I2C register bank.
package i2c_regmap_pkg;

  localparam logic [7:0] CFG_BASE = 8'h40;
  localparam logic [7:0] CTRL_IDX = 8'h4F;
  localparam logic [7:0] STAT_IDX = 8'h50;
  localparam logic [7:0] LAST_IDX = 8'h53;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_EN_REQ_BIT = 1;
  localparam int CTRL_CLEAR_BIT  = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR     = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/bank_wdt.sv
// Commit watchdog: counts cycles while the motor is enabled and flags a trip
// when WDT_CYCLES elapse without a kick. WDT_CYCLES of zero disables it.
module bank_wdt #(
  parameter logic [31:0] WDT_CYCLES = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic trip
);

  logic [31:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 32'd0;
    end else if ((WDT_CYCLES == 32'd0) || kick || !enable) begin
      cnt <= 32'd0;
    end else if (cnt != WDT_CYCLES) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Fires on the cycle whose increment reaches WDT_CYCLES.
  assign trip = (WDT_CYCLES != 32'd0) && enable && (cnt == WDT_CYCLES - 32'd1);

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave: shadow config bytes committed atomically
// to cfg_active, CTRL byte, live/snapshot status bytes and a commit watchdog.
module i2c_reg_bank
  import i2c_regmap_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR  = CFG_BASE,
  parameter int          NUM_CFG    = 15,
  parameter logic [31:0] WDT_CYCLES = 32'd50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i2c_wr,
  input  logic                 i2c_rd,
  input  logic [7:0]           i2c_index,
  input  logic [7:0]           i2c_wdata,
  output logic [7:0]           i2c_rdata,
  input  logic [31:0]          status_in,
  output logic [8*NUM_CFG-1:0] cfg_active,
  output logic                 motor_en,
  output logic                 commit_pulse,
  output logic                 wdt_trip,
  output logic                 wr_err
);

  localparam logic [7:0] NUM_CFG_B = 8'(NUM_CFG);

  state_t      state, state_d;
  logic        wr_d, rd_d, wr_rise, rd_rise;
  logic [7:0]  wr_idx, wr_dat, pend_idx, pend_dat;
  logic        pend, take_new, take_pend, do_wr, do_commit;
  logic        ctrl_wr, bad_wr, clr_flags, wdt_hit, en_req;
  logic [7:0]  shadow [NUM_CFG];
  logic [23:0] snapshot;
  logic [7:0]  wr_off, rd_off, rd_mux;
  logic        wr_cfg_hit, rd_cfg_hit;

  // Handshake: i2c_wr is a level and only its rising edge launches one write;
  // i2c_rd is a strobe whose rising edge only matters for the status snapshot.
  // A rise while the FSM is busy parks in a one-entry pending slot.
  assign wr_rise = i2c_wr & ~wr_d;
  assign rd_rise = i2c_rd & ~rd_d;

  assign wr_off     = wr_idx - BASE_ADDR;
  assign rd_off     = i2c_index - BASE_ADDR;
  assign wr_cfg_hit = (wr_idx >= BASE_ADDR) && (wr_off < NUM_CFG_B);
  assign rd_cfg_hit = (i2c_index >= BASE_ADDR) && (rd_off < NUM_CFG_B);

  assign ctrl_wr   = do_wr && !wr_cfg_hit && (wr_idx == CTRL_IDX);
  assign bad_wr    = do_wr && !wr_cfg_hit && (wr_idx != CTRL_IDX);
  assign clr_flags = ctrl_wr && wr_dat[CTRL_CLEAR_BIT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    take_new  = 1'b0;
    take_pend = 1'b0;
    do_wr     = 1'b0;
    do_commit = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend) begin
          take_pend = 1'b1;
          state_d   = S_WR;
        end else if (wr_rise) begin
          take_new = 1'b1;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        do_wr   = 1'b1;
        state_d = (!wr_cfg_hit && (wr_idx == CTRL_IDX) && wr_dat[CTRL_COMMIT_BIT])
                  ? S_COMMIT : S_IDLE;
      end
      S_COMMIT: begin
        do_commit = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_d     <= 1'b0;
      rd_d     <= 1'b0;
      wr_idx   <= 8'h00;
      wr_dat   <= 8'h00;
      pend     <= 1'b0;
      pend_idx <= 8'h00;
      pend_dat <= 8'h00;
    end else begin
      wr_d <= i2c_wr;
      rd_d <= i2c_rd;
      if (take_pend) begin
        wr_idx <= pend_idx;
        wr_dat <= pend_dat;
      end else if (take_new) begin
        wr_idx <= i2c_index;
        wr_dat <= i2c_wdata;
      end
      if (wr_rise && !take_new) begin
        pend     <= 1'b1;
        pend_idx <= i2c_index;
        pend_dat <= i2c_wdata;
      end else if (take_pend) begin
        pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CFG; k++) shadow[k] <= 8'h00;
      en_req   <= 1'b0;
      wr_err   <= 1'b0;
      wdt_trip <= 1'b0;
    end else begin
      if (do_wr && wr_cfg_hit) begin
        for (int k = 0; k < NUM_CFG; k++)
          if (wr_off == 8'(k)) shadow[k] <= wr_dat;
      end
      if (ctrl_wr) en_req <= wr_dat[CTRL_EN_REQ_BIT];
      if (bad_wr)         wr_err <= 1'b1;
      else if (clr_flags) wr_err <= 1'b0;
      // A trip in the same cycle as a clear still leaves the flag set.
      if (wdt_hit)        wdt_trip <= 1'b1;
      else if (clr_flags) wdt_trip <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_active   <= '0;
      motor_en     <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= do_commit;
      if (do_commit) begin
        for (int k = 0; k < NUM_CFG; k++) cfg_active[8*k +: 8] <= shadow[k];
        motor_en <= en_req;
      end else if (wdt_hit) begin
        motor_en <= 1'b0;
      end
    end
  end

  bank_wdt #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .enable (motor_en),
    .kick   (do_commit),
    .trip   (wdt_hit)
  );

  always_comb begin
    rd_mux = 8'h00;
    if (rd_cfg_hit) begin
      for (int k = 0; k < NUM_CFG; k++)
        if (rd_off == 8'(k)) rd_mux = shadow[k];
    end else begin
      case (i2c_index)
        CTRL_IDX:        rd_mux[CTRL_EN_REQ_BIT] = en_req;
        STAT_IDX:        rd_mux = status_in[7:0];
        STAT_IDX + 8'd1: rd_mux = snapshot[7:0];
        STAT_IDX + 8'd2: rd_mux = snapshot[15:8];
        LAST_IDX:        rd_mux = snapshot[23:16];
        default:         rd_mux = 8'h00;
      endcase
    end
  end

  // Upper status bytes are frozen when byte0 is read so a multi-byte read is coherent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot  <= 24'h0;
      i2c_rdata <= 8'h00;
    end else begin
      if (rd_rise && (i2c_index == STAT_IDX)) snapshot <= status_in[31:8];
      i2c_rdata <= rd_mux;
    end
  end

endmodule
